// File: rtl/control_temporizador.sv
// Programmable interval timer: latches a period at start and sequences an N-bit
// up-counter through IDLE, RUN, PAUSED and a one-cycle DONE for one-shot runs.
module control_temporizador #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         stop,
   input  logic         pause,
   input  logic         modo,
   input  logic [N-1:0] periodo,
   output logic [N-1:0] q,
   output logic         busy,
   output logic         tick,
   output logic         done,
   output logic [1:0]   estado
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSED = 2'b10,
      DONE   = 2'b11
   } state_t;

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   state_t       state;
   logic [N-1:0] periodo_reg;
   logic         modo_reg;
   logic         at_term;

   assign at_term = (q == periodo_reg);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         q           <= '0;
         periodo_reg <= '0;
         modo_reg    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               q <= '0;
               if (start && !stop && (periodo != '0)) begin
                  periodo_reg <= periodo;
                  modo_reg    <= modo;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
                  q     <= '0;
               end else if (pause) begin
                  state <= PAUSED;
               end else if (!at_term) begin
                  q <= q + ONE;
               end else if (modo_reg) begin
                  q <= '0;
               end else begin
                  state <= DONE;
               end
            end
            PAUSED: begin
               if (stop) begin
                  state <= IDLE;
                  q     <= '0;
               end else if (!pause) begin
                  // The release edge also counts, so each paused cycle costs exactly
                  // one cycle. At terminal count the tick cycle still has to be shown.
                  state <= RUN;
                  if (!at_term) q <= q + ONE;
               end
            end
            default: begin
               state <= IDLE;
               q     <= '0;
            end
         endcase
      end
   end

   assign estado = state;
   assign busy   = (state == RUN) || (state == PAUSED);
   assign done   = (state == DONE);
   assign tick   = (state == RUN) && at_term && !pause && !stop;

endmodule

// File: tb/tb_control_temporizador.sv
// Directed-vector bench: the driver queues hand-computed per-cycle expectations,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_control_temporizador;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, stop, pause, modo;
   logic [3:0] periodo;
   logic [3:0] q;
   logic       busy, tick, done;
   logic [1:0] estado;

   typedef struct packed {
      logic [3:0] q;
      logic [1:0] est;
      logic       busy;
      logic       tick;
      logic       done;
   } exp_t;

   exp_t  sb[$];
   string tags[$];
   int    errors = 0;
   int    checks = 0;

   localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAU = 2'b10, S_DONE = 2'b11;

   control_temporizador #(.N(4)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
      .modo(modo), .periodo(periodo), .q(q), .busy(busy), .tick(tick),
      .done(done), .estado(estado)
   );

   always #5 clk = ~clk;

   task automatic compare(input string name, input exp_t e);
      exp_t a;
      a = '{q: q, est: estado, busy: busy, tick: tick, done: done};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got q=%0d est=%b busy=%b tick=%b done=%b, want q=%0d est=%b busy=%b tick=%b done=%b",
                  name, a.q, a.est, a.busy, a.tick, a.done, e.q, e.est, e.busy, e.tick, e.done);
      end
   endtask

   // Monitor: outputs are presented every cycle, checked mid-cycle
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t  e;
         string t;
         e = sb.pop_front();
         t = tags.pop_front();
         compare(t, e);
      end
   end

   // One cycle: drive inputs just after the edge, queue the outputs expected in that cycle
   task automatic cyc(input string name, input logic st, input logic sp, input logic pa,
                      input logic mo, input logic [3:0] per,
                      input logic [3:0] eq, input logic [1:0] es,
                      input logic eb, input logic et, input logic ed);
      @(posedge clk);
      #1;
      start = st; stop = sp; pause = pa; modo = mo; periodo = per;
      sb.push_back('{q: eq, est: es, busy: eb, tick: et, done: ed});
      tags.push_back(name);
   endtask

   initial begin
      reset = 1'b0; start = 0; stop = 0; pause = 0; modo = 0; periodo = 4'd0;
      #3;
      compare("reset_state", '{q: 4'd0, est: S_IDLE, busy: 1'b0, tick: 1'b0, done: 1'b0});
      #10 reset = 1'b1;

      // One-shot P=3
      cyc("os_start", 1, 0, 0, 0, 4'd3, 4'd0, S_IDLE, 0, 0, 0);
      cyc("os_q0",    0, 0, 0, 0, 4'd3, 4'd0, S_RUN,  1, 0, 0);
      cyc("os_q1",    0, 0, 0, 0, 4'd3, 4'd1, S_RUN,  1, 0, 0);
      cyc("os_q2",    0, 0, 0, 0, 4'd3, 4'd2, S_RUN,  1, 0, 0);
      cyc("os_tick",  0, 0, 0, 0, 4'd3, 4'd3, S_RUN,  1, 1, 0);
      cyc("os_done",  0, 0, 0, 0, 4'd3, 4'd3, S_DONE, 0, 0, 1);
      cyc("os_idle",  0, 0, 0, 0, 4'd3, 4'd0, S_IDLE, 0, 0, 0);

      // Periodic full scale P=15: three periods, wrap 15->0, then stop
      cyc("per_start", 1, 0, 0, 1, 4'd15, 4'd0, S_IDLE, 0, 0, 0);
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 16; i++)
            cyc("per_run", 0, 0, 0, 1, 4'd15, 4'(i), S_RUN, 1, (i == 15), 0);
      cyc("per_stop",  0, 1, 0, 1, 4'd15, 4'd0, S_RUN,  1, 0, 0);
      cyc("per_idle",  0, 0, 0, 1, 4'd15, 4'd0, S_IDLE, 0, 0, 0);

      // Pause 3 cycles at q=2, P=5 one-shot: tick 3 cycles late
      cyc("pz_start",  1, 0, 0, 0, 4'd5, 4'd0, S_IDLE, 0, 0, 0);
      cyc("pz_q0",     0, 0, 0, 0, 4'd5, 4'd0, S_RUN,  1, 0, 0);
      cyc("pz_q1",     0, 0, 0, 0, 4'd5, 4'd1, S_RUN,  1, 0, 0);
      cyc("pz_q2_p",   0, 0, 1, 0, 4'd5, 4'd2, S_RUN,  1, 0, 0);
      cyc("pz_hold1",  0, 0, 1, 0, 4'd5, 4'd2, S_PAU,  1, 0, 0);
      cyc("pz_hold2",  0, 0, 1, 0, 4'd5, 4'd2, S_PAU,  1, 0, 0);
      cyc("pz_rel",    0, 0, 0, 0, 4'd5, 4'd2, S_PAU,  1, 0, 0);
      cyc("pz_q3",     0, 0, 0, 0, 4'd5, 4'd3, S_RUN,  1, 0, 0);
      cyc("pz_q4",     0, 0, 0, 0, 4'd5, 4'd4, S_RUN,  1, 0, 0);
      cyc("pz_tick",   0, 0, 0, 0, 4'd5, 4'd5, S_RUN,  1, 1, 0);
      cyc("pz_done",   0, 0, 0, 0, 4'd5, 4'd5, S_DONE, 0, 0, 1);
      cyc("pz_idle",   0, 0, 0, 0, 4'd5, 4'd0, S_IDLE, 0, 0, 0);

      // Stop at q=1
      cyc("sp_start",  1, 0, 0, 0, 4'd6, 4'd0, S_IDLE, 0, 0, 0);
      cyc("sp_q0",     0, 0, 0, 0, 4'd6, 4'd0, S_RUN,  1, 0, 0);
      cyc("sp_q1",     0, 1, 0, 0, 4'd6, 4'd1, S_RUN,  1, 0, 0);
      cyc("sp_idle",   0, 0, 0, 0, 4'd6, 4'd0, S_IDLE, 0, 0, 0);

      // start+stop together, start with periodo=0
      cyc("ss_both",   1, 1, 0, 0, 4'd6, 4'd0, S_IDLE, 0, 0, 0);
      cyc("ss_stay",   1, 0, 0, 0, 4'd0, 4'd0, S_IDLE, 0, 0, 0);
      cyc("p0_stay",   0, 0, 0, 0, 4'd0, 4'd0, S_IDLE, 0, 0, 0);

      // Stop while paused
      cyc("sw_start",  1, 0, 0, 0, 4'd4, 4'd0, S_IDLE, 0, 0, 0);
      cyc("sw_q0",     0, 0, 0, 0, 4'd4, 4'd0, S_RUN,  1, 0, 0);
      cyc("sw_q1_p",   0, 0, 1, 0, 4'd4, 4'd1, S_RUN,  1, 0, 0);
      cyc("sw_pstop",  0, 1, 1, 0, 4'd4, 4'd1, S_PAU,  1, 0, 0);
      cyc("sw_idle",   0, 0, 0, 0, 4'd4, 4'd0, S_IDLE, 0, 0, 0);

      // start while busy / in DONE ignored, periodo/modo changes mid-run ignored
      cyc("ig_start",  1, 0, 0, 0, 4'd3, 4'd0, S_IDLE, 0, 0, 0);
      cyc("ig_q0",     1, 0, 0, 1, 4'd9, 4'd0, S_RUN,  1, 0, 0);
      cyc("ig_q1",     1, 0, 0, 1, 4'd9, 4'd1, S_RUN,  1, 0, 0);
      cyc("ig_q2",     0, 0, 0, 1, 4'd9, 4'd2, S_RUN,  1, 0, 0);
      cyc("ig_tick",   0, 0, 0, 1, 4'd9, 4'd3, S_RUN,  1, 1, 0);
      cyc("ig_done",   1, 0, 0, 1, 4'd9, 4'd3, S_DONE, 0, 0, 1);
      cyc("ig_idle",   0, 0, 0, 1, 4'd9, 4'd0, S_IDLE, 0, 0, 0);

      // Reset mid-run, periodic, at q=5
      cyc("rs_start",  1, 0, 0, 1, 4'd15, 4'd0, S_IDLE, 0, 0, 0);
      for (int i = 0; i < 6; i++)
         cyc("rs_run", 0, 0, 0, 1, 4'd15, 4'(i), S_RUN, 1, 0, 0);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 compare("rs_async", '{q: 4'd0, est: S_IDLE, busy: 1'b0, tick: 1'b0, done: 1'b0});
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      for (int i = 0; i < 3; i++)
         cyc("rs_after", 0, 0, 0, 1, 4'd15, 4'd0, S_IDLE, 0, 0, 0);

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
